// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit for the EX stage.
// Stalls the pipeline while busy and presents a one-cycle result.
module ex_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int ADR_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_muldiv_ex,
  input  logic [2:0]       alu_code_ex,
  input  logic [XLEN-1:0]  rs1_sel,
  input  logic [XLEN-1:0]  rs2_sel,
  input  logic [ADR_W-1:0] rd_adr_ex,
  input  logic             stall,
  input  logic             rst_pipe,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [XLEN-1:0]  muldiv_rd_data,
  output logic [ADR_W-1:0] muldiv_rd_adr
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [ADR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic accept, div_in, sgn_in, div_zero, div_ovf;
  logic a_neg, b_neg;

  assign accept   = (state_q == S_IDLE) & cmd_muldiv_ex & ~rst_pipe;
  assign div_in   = alu_code_ex[2];
  assign sgn_in   = ~alu_code_ex[0];
  assign div_zero = (rs2_sel == '0);
  assign div_ovf  = sgn_in & (rs1_sel == SMIN) & (rs2_sel == '1);
  assign a_neg    = sgn_in & rs1_sel[XLEN-1];
  assign b_neg    = sgn_in & rs2_sel[XLEN-1];

  // 2*XLEN-wide extension keeps the low 2*XLEN product bits exact
  logic a_ext, b_ext;
  logic [2*XLEN-1:0] a_x, b_x, prod;

  assign a_ext = ~(op_q[1] & op_q[0]) & a_q[XLEN-1];
  assign b_ext = ~op_q[1] & b_q[XLEN-1];
  assign a_x   = {{XLEN{a_ext}}, a_q};
  assign b_x   = {{XLEN{b_ext}}, b_q};
  assign prod  = a_x * b_x;

  logic [XLEN:0] diff;
  logic          q_neg, r_neg;

  assign diff  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign q_neg = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg = ~op_q[0] & a_q[XLEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rst_pipe) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (cmd_muldiv_ex) begin
            if (!div_in)                state_d = S_MUL;
            else if (div_zero | div_ovf) state_d = S_DONE;
            else                        state_d = S_DIV;
          end
        S_MUL:  if (cnt_q == '0) state_d = S_DONE;
        S_DIV:  if (cnt_q == '0) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (!stall) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    muldiv_busy = accept | (state_q == S_MUL) |
                  (state_q == S_DIV) | (state_q == S_FIX);
    muldiv_done = (state_q == S_DONE);
  end

  assign muldiv_rd_data = res_q;
  assign muldiv_rd_adr  = rd_q;

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    res_d = res_q;
    unique case (state_q)
      S_IDLE:
        if (accept) begin
          op_d = alu_code_ex;
          a_d  = rs1_sel;
          b_d  = rs2_sel;
          rd_d = rd_adr_ex;
          if (!div_in) begin
            cnt_d = CW'(MUL_LAT - 1);
          end else begin
            cnt_d = CW'(XLEN - 1);
            rem_d = '0;
            quo_d = a_neg ? -rs1_sel : rs1_sel;
            dvs_d = b_neg ? -rs2_sel : rs2_sel;
            if (div_zero)
              res_d = alu_code_ex[1] ? rs1_sel : '1;
            else if (div_ovf)
              res_d = alu_code_ex[1] ? '0 : rs1_sel;
          end
        end
      S_MUL: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else res_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                          : prod[2*XLEN-1:XLEN];
      end
      S_DIV: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_d = diff[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]}
                           : diff[XLEN-1:0];
      end
      S_FIX:
        res_d = op_q[1] ? (r_neg ? -rem_q : rem_q)
                        : (q_neg ? -quo_q : quo_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Random + directed bench for ex_muldiv_unit, run on a 32-bit
// (MUL_LAT=2) and a 64-bit (MUL_LAT=1) instance in lockstep.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd = 1'b0;
  logic [2:0]  code = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic [4:0]  rd = '0;
  logic        stall = 1'b0;
  logic        rst_pipe = 1'b0;

  logic        busy32, done32, busy64, done64;
  logic [31:0] data32;
  logic [63:0] data64;
  logic [4:0]  adr32, adr64;

  int total = 0;
  int bad = 0;
  logic        hold = 1'b0;
  logic [63:0] obs32;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .MUL_LAT(2), .ADR_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .cmd_muldiv_ex(cmd),
    .alu_code_ex(code), .rs1_sel(rs1[31:0]), .rs2_sel(rs2[31:0]),
    .rd_adr_ex(rd), .stall(stall), .rst_pipe(rst_pipe),
    .muldiv_busy(busy32), .muldiv_done(done32),
    .muldiv_rd_data(data32), .muldiv_rd_adr(adr32)
  );

  ex_muldiv_unit #(.XLEN(64), .MUL_LAT(1), .ADR_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .cmd_muldiv_ex(cmd),
    .alu_code_ex(code), .rs1_sel(rs1), .rs2_sel(rs2),
    .rd_adr_ex(rd), .stall(stall), .rst_pipe(rst_pipe),
    .muldiv_busy(busy64), .muldiv_done(done64),
    .muldiv_rd_data(data64), .muldiv_rd_adr(adr64)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic dn(input int id);
    return (id != 0) ? done64 : done32;
  endfunction

  function automatic logic bsy(input int id);
    return (id != 0) ? busy64 : busy32;
  endfunction

  function automatic logic [63:0] dat(input int id);
    return (id != 0) ? data64 : {32'h0, data32};
  endfunction

  function automatic logic [4:0] adr(input int id);
    return (id != 0) ? adr64 : adr32;
  endfunction

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? '1 : 64'hFFFF_FFFF;
  endfunction

  // Reference: RV M-extension semantics on w-bit operands
  function automatic logic [63:0] model(input int w, input logic [2:0] f,
                                        input logic [63:0] ai,
                                        input logic [63:0] bi);
    logic [63:0]  m, a, b, ma, mb, q, r;
    logic [127:0] ea, eb, p;
    logic         sa, sb, sg;
    m  = msk(w);
    a  = ai & m;
    b  = bi & m;
    sa = a[w-1];
    sb = b[w-1];
    if (!f[2]) begin
      ea = {64'h0, a};
      eb = {64'h0, b};
      if (f != 3'b011 && sa) ea = ea | ~{64'h0, m};
      if (!f[1] && sb)       eb = eb | ~{64'h0, m};
      p = ea * eb;
      if (f == 3'b000) return p[63:0] & m;
      p = p >> w;
      return p[63:0] & m;
    end
    if (b == 0) return f[1] ? a : m;
    sg = ~f[0];
    ma = (sg && sa) ? ((-a) & m) : a;
    mb = (sg && sb) ? ((-b) & m) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sg && (sa ^ sb)) q = (-q) & m;
    if (sg && sa)        r = (-r) & m;
    return f[1] ? r : q;
  endfunction

  function automatic int exp_lat(input int w, input int ml,
                                 input logic [2:0] f,
                                 input logic [63:0] ai,
                                 input logic [63:0] bi);
    logic [63:0] m, a, b, smin;
    m    = msk(w);
    a    = ai & m;
    b    = bi & m;
    smin = 64'h1 << (w - 1);
    if (!f[2]) return ml + 1;
    if (b == 0) return 1;
    if (!f[0] && a == smin && b == m) return 1;
    return w + 2;
  endfunction

  task automatic waiter(input int id, input int lat,
                        input logic [63:0] exp, input logic [4:0] erd);
    int cyc = 1;
    int bc = 1;
    logic [63:0] d;
    string px;
    px = (id != 0) ? "x64" : "x32";
    while (!dn(id) && cyc < 80) begin
      if (bsy(id)) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({px, " done"}, 64'(dn(id)), 64'd1);
    chk({px, " latency"}, 64'(cyc), 64'(lat));
    chk({px, " busy_cycles"}, 64'(bc), 64'(lat));
    chk({px, " busy_in_done"}, 64'(bsy(id)), 64'd0);
    chk({px, " data"}, dat(id), exp);
    chk({px, " rd_adr"}, 64'(adr(id)), 64'(erd));
    if (id == 0) obs32 = dat(0);
    if (hold) begin
      d = dat(id);
      repeat (4) begin
        @(posedge clk); #1;
        chk({px, " hold_done"}, 64'(dn(id)), 64'd1);
        chk({px, " hold_busy"}, 64'(bsy(id)), 64'd0);
        chk({px, " hold_data"}, dat(id), d);
      end
    end else begin
      @(posedge clk); #1;
      chk({px, " done_drop"}, 64'(dn(id)), 64'd0);
    end
  endtask

  // Entered #1 after a rising edge with both units idle
  task automatic do_op(input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r);
    int l32, l64;
    logic [63:0] e32, e64;
    l32 = exp_lat(32, 2, f, a, b);
    l64 = exp_lat(64, 1, f, a, b);
    e32 = model(32, f, a, b);
    e64 = model(64, f, a, b);
    cmd = 1'b1; code = f; rs1 = a; rs2 = b; rd = r;
    if (hold) stall = 1'b1;
    #1;
    chk("busy_accept32", 64'(busy32), 64'd1);
    chk("busy_accept64", 64'(busy64), 64'd1);
    @(posedge clk); #1;
    cmd = 1'b0;
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
    rd = 5'($urandom);
    code = 3'($urandom);
    fork
      waiter(0, l32, e32, r);
      waiter(1, l64, e64, r);
    join
    if (hold) begin
      stall = 1'b0;
      @(posedge clk); #1;
      chk("stall_release32", 64'(done32), 64'd0);
      chk("stall_release64", 64'(done64), 64'd0);
    end
  endtask

  function automatic logic [63:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [2:0]  df [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                           3'd6, 3'd5, 3'd7, 3'd5, 3'd7};
  logic [63:0] da [10] = '{64'd7, 64'h8000_0000, 64'h8000_0000,
                           64'h8000_0000, '1 - 64'd6, '1 - 64'd6,
                           64'd100, 64'd100, 64'h1234_5678,
                           64'h1234_5678};
  logic [63:0] db [10] = '{'1 - 64'd2, 64'h8000_0000, 64'h8000_0000,
                           64'h8000_0000, 64'd2, 64'd2, 64'd7, 64'd7,
                           64'd0, 64'd0};
  logic [31:0] de [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hC000_0000,
                           32'h4000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                           32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678};

  initial begin
    int pulses;
    #2;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_data32", 64'(data32), 64'd0);
    chk("rst_adr32", 64'(adr32), 64'd0);
    chk("rst_done64", 64'(done64), 64'd0);
    chk("rst_data64", data64, 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(df[i], da[i], db[i], 5'(i + 3));
      chk($sformatf("directed%0d", i), obs32, {32'h0, de[i]});
    end

    do_op(3'd4, 64'h8000_0000, '1, 5'd9);
    chk("div_ovf32", obs32, 64'h8000_0000);
    do_op(3'd6, 64'h8000_0000, '1, 5'd10);
    chk("rem_ovf32", obs32, 64'h0);

    // Flush in the middle of a divide
    cmd = 1'b1; code = 3'd4; rs1 = 64'd1000; rs2 = 64'd3; rd = 5'd7;
    @(posedge clk); #1;
    cmd = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_pipe = 1'b1;
    @(posedge clk); #1;
    rst_pipe = 1'b0;
    chk("flush_busy32", 64'(busy32), 64'd0);
    chk("flush_busy64", 64'(busy64), 64'd0);
    pulses = 0;
    repeat (80) begin
      if (done32 || done64) pulses++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 64'(pulses), 64'd0);
    do_op(3'd4, 64'd1000, 64'd3, 5'd11);
    chk("after_flush32", obs32, 64'd333);

    hold = 1'b1;
    do_op(3'd0, 64'd7, '1 - 64'd2, 5'd12);
    do_op(3'd6, '1 - 64'd6, 64'd2, 5'd13);
    hold = 1'b0;

    for (int i = 0; i < 40; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      do_op(3'($urandom), pick(), pick(), 5'($urandom));
    end
    hold = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide execution unit that adds the RV32M instruction group beside the single-cycle integer ALU in the EX stage. It takes already-forwarded operands and funct3 from EX. While it works, it asserts a stall request that freezes the pipeline. It then presents a one-cycle result for the EX->MA register. Width, multiply latency and destination-address width are parameters, so the same block also serves a future RV64 core.

Parameters:
XLEN, 32, operand/result width (power of two, >=8)
MUL_LAT, 2, cycles spent in MUL state (1..8)
ADR_W, 5, destination register address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cmd_muldiv_ex  in  1  M-extension instruction valid in EX
alu_code_ex  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_sel  in  XLEN  forwarded rs1 operand (dividend / multiplicand)
rs2_sel  in  XLEN  forwarded rs2 operand (divisor / multiplier)
rd_adr_ex  in  ADR_W  destination register
stall  in  1  external pipeline stall (dc_stall etc.)
rst_pipe  in  1  synchronous pipeline flush
muldiv_busy  out  1  stall request to pipeline control
muldiv_done  out  1  result valid this cycle
muldiv_rd_data  out  XLEN  result
muldiv_rd_adr  out  ADR_W  destination of result

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE; all internal registers 0.
  - muldiv_done=0, muldiv_rd_data=0, muldiv_rd_adr=0.
  - muldiv_busy=0 (cmd_muldiv_ex is low during reset).
- States: IDLE, MUL, DIV, FIX, DONE.
- Operand capture:
  - Operands, funct3 and rd_adr_ex are latched in IDLE when cmd_muldiv_ex & ~rst_pipe.
  - Inputs are ignored in every other state.
- IDLE transitions on accept:
  - funct3[2]=0 -> MUL.
  - Divide with divisor==0 -> DONE: quotient all-ones; remainder = dividend.
  - Signed DIV/REM with dividend=1<<(XLEN-1) and divisor all-ones -> DONE: quotient = dividend; remainder = 0.
  - Any other divide -> DIV.
- MUL:
  - Operands are extended to XLEN+1 bits: signed for MUL/MULH; rs1 signed, rs2 unsigned for MULHSU; unsigned for MULHU.
  - Full 2*XLEN product is formed.
  - Down-counter is loaded with MUL_LAT-1; the unit moves to DONE when the counter is 0.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- DIV:
  - Radix-2 restoring division on magnitudes, one bit per cycle, exactly XLEN cycles.
  - Counter width is $clog2(XLEN)+1.
  - Unit then goes to FIX.
- FIX (1 cycle):
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Next state is DONE.
- DONE:
  - muldiv_done=1; muldiv_rd_data/muldiv_rd_adr hold the result.
  - Unit stays in DONE while stall=1, then goes to IDLE.
  - The data outputs stay stable until the next accept.
- Latency from accept cycle T:
  - MUL: done at T+MUL_LAT+1.
  - Normal divide: done at T+XLEN+2.
  - Special-case divide: done at T+1.
- muldiv_busy = (IDLE & cmd_muldiv_ex & ~rst_pipe) | MUL | DIV | FIX. It is combinational and 0 in DONE, so the pipeline advances exactly once with the result.
- Back-to-back: a new M instruction can be accepted in IDLE the cycle after DONE exits.
- rst_pipe:
  - Any state -> IDLE on the next edge; muldiv_done=0 from then on.
  - rst_pipe has priority over stall and over accept.
- stall does not pause MUL/DIV/FIX progress; it only extends DONE.
- Arithmetic is modulo 2^XLEN; no exceptions are raised.

Test Plan:
- MUL 7 x 0xFFFFFFFD, MUL_LAT=2 -> busy for 3 cycles; done at T+3 with 0xFFFFFFEB; rd_adr echoed.
- MULH/MULHSU/MULHU with 0x80000000 x 0x80000000 -> 0x40000000, 0xC0000000, 0x40000000.
- DIV/REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and 0xFFFFFFFF; DIVU 100/7=14, REMU=2; done at T+34.
- DIVU/REMU with 0x12345678 / 0 -> 0xFFFFFFFF and 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; done at T+1, busy 1 cycle.
- Assert rst_pipe at DIV iteration 10 -> IDLE next cycle, busy=0, no done pulse; a fresh DIV is then accepted and returns the correct result.
- Hold stall=1 for 4 cycles while in DONE -> done and data held 4 extra cycles; busy=0 throughout; IDLE after stall drops. Repeat with XLEN=64 and MUL_LAT=1 to cover the parameters.
